// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, arbiter FSM states and datapath widths.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SRA = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU: modulo-2^32 arithmetic, logic ops and
// shifts that use only b[4:0] as the shift amount.
module alu
    import alu_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    logic signed [DATA_W-1:0] a_s;
    logic [SHAMT_W-1:0]       shamt;

    assign a_s   = a;
    assign shamt = b[SHAMT_W-1:0];

    // Select the operation; SRA sign-fills through the signed view of a.
    always_comb begin
        result = '0;
        case (alu_op_e'(op))
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned(a_s >>> shamt);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU. One operation in flight:
// IDLE grants (round-robin on contention), EXEC registers the ALU result,
// RESP presents it to the owner until that owner consumes it.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_opcode,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_opcode,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp0_negative,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,
    output logic        rsp1_negative,

    output logic        busy
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;      // requester granted most recently
    logic              owner_q, owner_d;    // requester owning the in-flight op
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res0_q, res0_d;      // per-port results so the
    logic [DATA_W-1:0] res1_q, res1_d;      // non-owner keeps its last value

    logic              any_valid;
    logic              grant;
    logic              accept;
    logic              owner_ready;
    logic [DATA_W-1:0] alu_result;

    assign any_valid   = req0_valid | req1_valid;
    assign accept      = rst_n & (state_q == ST_IDLE) & any_valid;
    assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

    // Round-robin pick: on contention the requester not granted last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = req1_valid;
        end
    end

    // Single shared ALU, always fed from the captured operands.
    alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (owner_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; ready is forced low while reset is asserted.
    always_comb begin
        req0_ready = accept & ~grant;
        req1_ready = accept &  grant;
        rsp0_valid = (state_q == ST_RESP) & ~owner_q;
        rsp1_valid = (state_q == ST_RESP) &  owner_q;
        busy       = (state_q != ST_IDLE);
    end

    // Datapath next values: capture on grant, register ALU output in EXEC.
    always_comb begin
        last_d  = last_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        if (accept) begin
            last_d  = grant;
            owner_d = grant;
            op_d    = grant ? req1_opcode : req0_opcode;
            a_d     = grant ? req1_a      : req0_a;
            b_d     = grant ? req1_b      : req0_b;
        end
        if (state_q == ST_EXEC) begin
            if (owner_q) begin
                res1_d = alu_result;
            end else begin
                res0_d = alu_result;
            end
        end
    end

    // Datapath registers; the grant pointer resets to 1 so port 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
        end else begin
            last_q  <= last_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
        end
    end

    // Flags come from the registered results, not from the ALU.
    assign rsp0_result   = res0_q;
    assign rsp0_zero     = (res0_q == '0);
    assign rsp0_negative = res0_q[DATA_W-1];
    assign rsp1_result   = res1_q;
    assign rsp1_zero     = (res1_q == '0);
    assign rsp1_negative = res1_q[DATA_W-1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: inputs driven on the falling edge,
// outputs sampled on the falling edge (plus #1 for combinational ready).
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_opcode, req1_opcode;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero, rsp0_negative, rsp1_negative;
    logic        busy;

    int n_tests;
    int n_fail;

    alu_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_opcode   (req0_opcode),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_opcode   (req1_opcode),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .rsp0_valid    (rsp0_valid),
        .rsp0_ready    (rsp0_ready),
        .rsp0_result   (rsp0_result),
        .rsp0_zero     (rsp0_zero),
        .rsp0_negative (rsp0_negative),
        .rsp1_valid    (rsp1_valid),
        .rsp1_ready    (rsp1_ready),
        .rsp1_result   (rsp1_result),
        .rsp1_zero     (rsp1_zero),
        .rsp1_negative (rsp1_negative),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_opcode = 3'd0; req1_opcode = 3'd0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one op on port n with immediate response ready; no checking here,
    // it only reports whether the handshakes happened and what came back.
    task automatic run_op(input int n, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output bit got);
        int k;
        got = 1'b0;
        res = '0;
        @(negedge clk);
        if (n == 0) begin req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b; end
        else        begin req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b; end
        #1;
        k = 0;
        while (((n == 0) ? req0_ready : req1_ready) !== 1'b1 && k < 20) begin
            @(negedge clk); #1; k++;
        end
        if (k >= 20) begin req0_valid = 1'b0; req1_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        k = 0;
        while (((n == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 && k < 20) begin
            @(negedge clk); k++;
        end
        if (k >= 20) return;
        res = (n == 0) ? rsp0_result : rsp1_result;
        if (n == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        got = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy0=%b rdy1=%b vld0=%b vld1=%b busy=%b, want all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy);
        end
        n_tests++;
        if ({rsp0_result, rsp1_result} !== 64'h0 || {rsp0_zero, rsp1_zero} !== 2'b11 ||
            {rsp0_negative, rsp1_negative} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_data: got r0=%h r1=%h z=%b%b n=%b%b, want 0 0 z=11 n=00",
                     rsp0_result, rsp1_result, rsp0_zero, rsp1_zero, rsp0_negative, rsp1_negative);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        @(negedge clk);
        req0_valid = 1'b1; req0_opcode = 3'b000; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        n_tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant: got rdy0=%b rdy1=%b, want 1 0", req0_ready, req1_ready);
        end
        @(posedge clk);   // accept edge T
        @(negedge clk);
        req0_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_exec: got busy=%b vld0=%b rdy0=%b, want 1 0 0", busy, rsp0_valid, req0_ready);
        end
        @(negedge clk);
        n_tests++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd12 || rsp0_zero !== 1'b0 ||
            rsp0_negative !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp: got vld0=%b res=%h z=%b n=%b vld1=%b, want 1 0000000c 0 0 0",
                     rsp0_valid, rsp0_result, rsp0_zero, rsp0_negative, rsp1_valid);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got busy=%b vld0=%b, want 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_opcode = 3'b001; req0_a = 32'd3; req0_b = 32'd3;
        req1_valid = 1'b1; req1_opcode = 3'b100; req1_a = 32'hFFFF0000; req1_b = 32'h0000FFFF;
        #1;
        n_tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL contend_first: got rdy0=%b rdy1=%b, want 1 0", req0_ready, req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h0 || rsp0_zero !== 1'b1 ||
            rsp1_valid !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL contend_rsp0: got vld0=%b res=%h z=%b vld1=%b rdy1=%b, want 1 0 1 0 0",
                     rsp0_valid, rsp0_result, rsp0_zero, rsp1_valid, req1_ready);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        #1;
        n_tests++;
        if (req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL contend_second: got rdy1=%b, want 1", req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hFFFFFFFF || rsp1_negative !== 1'b1 ||
            rsp1_zero !== 1'b0 || rsp0_valid !== 1'b0 || rsp0_result !== 32'h0) begin
            n_fail++;
            $display("FAIL contend_rsp1: got vld1=%b res=%h n=%b z=%b vld0=%b r0=%h, want 1 ffffffff 1 0 0 0",
                     rsp1_valid, rsp1_result, rsp1_negative, rsp1_zero, rsp0_valid, rsp0_result);
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic exp_owner;
        @(negedge clk);
        req0_valid = 1'b1; req0_opcode = 3'b000; req0_a = 32'd100; req0_b = 32'd1;
        req1_valid = 1'b1; req1_opcode = 3'b001; req1_a = 32'd100; req1_b = 32'd1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_owner = i[0];
            #1;
            n_tests++;
            if (req0_ready !== ~exp_owner || req1_ready !== exp_owner) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got rdy0=%b rdy1=%b, want %b %b",
                         i, req0_ready, req1_ready, ~exp_owner, exp_owner);
            end
            @(posedge clk);
            @(negedge clk);
            @(negedge clk);
            n_tests++;
            if (rsp0_valid !== ~exp_owner || rsp1_valid !== exp_owner ||
                (exp_owner ? rsp1_result : rsp0_result) !== (exp_owner ? 32'd99 : 32'd101)) begin
                n_fail++;
                $display("FAIL rr_resp[%0d]: got vld0=%b vld1=%b r0=%0d r1=%0d, want owner %0d result %0d",
                         i, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result, exp_owner,
                         exp_owner ? 99 : 101);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_back_pressure();
        logic [31:0] held;
        @(negedge clk);
        req1_valid = 1'b1; req1_opcode = 3'b011; req1_a = 32'hA0A0_0000; req1_b = 32'h0000_0505;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_opcode = 3'b000; req0_a = 32'd1; req0_b = 32'd1;
        @(negedge clk);
        held = rsp1_result;
        n_tests++;
        if (held !== 32'hA0A0_0505) begin
            n_fail++;
            $display("FAIL bp_result: got %h, want a0a00505", held);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hA0A0_0505 || req0_ready !== 1'b0 ||
                rsp0_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got vld1=%b res=%h rdy0=%b vld0=%b busy=%b, want 1 a0a00505 0 0 1",
                         i, rsp1_valid, rsp1_result, req0_ready, rsp0_valid, busy);
            end
            @(negedge clk);
        end
        rsp0_ready = 1'b1;   // non-owner ready must be ignored
        @(negedge clk);
        n_tests++;
        if (rsp1_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_nonowner_ready: got vld1=%b busy=%b, want 1 1", rsp1_valid, busy);
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got busy=%b vld1=%b, want 0 0", busy, rsp1_valid);
        end
        idle_inputs();
    endtask

    task automatic test_shifts();
        logic [31:0] res;
        bit got;
        logic [2:0]  ops  [6] = '{3'b111, 3'b110, 3'b101, 3'b001, 3'b010, 3'b000};
        logic [31:0] as   [6] = '{32'h80000000, 32'h80000000, 32'h1, 32'h0, 32'hF0F0_1234, 32'hFFFF_FFFF};
        logic [31:0] bs   [6] = '{32'h24, 32'h24, 32'd31, 32'h1, 32'h0FF0_FF00, 32'h2};
        logic [31:0] exps [6] = '{32'hF8000000, 32'h08000000, 32'h80000000, 32'hFFFFFFFF,
                                  32'h00F0_1200, 32'h1};
        for (int i = 0; i < 6; i++) begin
            run_op(0, ops[i], as[i], bs[i], res, got);
            n_tests++;
            if (!got || res !== exps[i]) begin
                n_fail++;
                $display("FAIL alu_op[%0d]: handshake=%0d got %h, want %h", i, got, res, exps[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        bit got;
        @(negedge clk);
        req0_valid = 1'b1; req0_opcode = 3'b000; req0_a = 32'd1; req0_b = 32'd2;
        @(posedge clk);
        @(negedge clk);      // EXEC
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0 ||
            rsp0_result !== 32'h0 || rsp0_zero !== 1'b1 || rsp1_result !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_async: got vld=%b%b busy=%b r0=%h z0=%b r1=%h, want 00 0 0 1 0",
                     rsp0_valid, rsp1_valid, busy, rsp0_result, rsp0_zero, rsp1_result);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_held: got vld0=%b busy=%b, want 0 0", rsp0_valid, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_abort: got vld0=%b busy=%b, want 0 0", rsp0_valid, busy);
        end
        run_op(1, 3'b000, 32'd10, 32'd20, res, got);
        n_tests++;
        if (!got || res !== 32'd30) begin
            n_fail++;
            $display("FAIL midreset_req1: handshake=%0d got %0d, want 30", got, res);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single_op();
        test_contention();
        test_round_robin();
        test_back_pressure();
        test_shifts();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
